digit_serial_adder: RTL and testbench

Parametrised digit-serial adder/subtractor, the next generation of our 2-bit mux-based adder cell. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first. It produces sum, carry-out and signed overflow after WIDTH/DIGIT cycles. Start/done handshake; sits between operand registers and the result bus of the datapath labs.

---
 rtl/adder_pkg.sv | 15 +
 rtl/digit_add_cell.sv | 21 ++
 rtl/digit_serial_adder.sv | 117 +++++++++++
 tb/tb_digit_serial_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: enough bits to hold 0..ndig.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig < 1) ? 1 : $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/digit_add_cell.sv
// Combinational DIGIT-bit adder slice with carry out and carry into its top bit.
module digit_add_cell #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign s     = w_sum[DIGIT-1:0];
  assign cout  = w_sum[DIGIT];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign c_msb = w_sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSD first.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % ((DIGIT == 0) ? 1 : DIGIT)) != 0)) begin : g_bad_digit
      $error("digit_serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  digit_add_cell #(.DIGIT(DIGIT)) u_cell (
    .a     (r_sha[DIGIT-1:0]),
    .b     (r_shb[DIGIT-1:0]),
    .cin   (r_c),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // New digit enters the partial result from the top; after NDIG digits it is aligned.
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_sha   <= '0;
      r_shb   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sha   <= A;
            r_shb   <= sub ? ~B : B;
            r_c     <= sub | ci;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_sha <= r_sha >> DIGIT;
          r_shb <= r_shb >> DIGIT;
          r_c   <= w_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_s     <= w_acc_next;
            r_co    <= w_cout;
            r_ovf   <= w_cout ^ w_c_msb;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks of digit_serial_adder at WIDTH=8 with DIGIT 2, 1, 4 and 8.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] start_v = 4'h0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       ci = 1'b0;
  logic       sub = 1'b0;
  logic [3:0] busy_v, done_v, co_v, ovf_v;
  logic [7:0] s_v [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instance 0: DIGIT=2, 1: DIGIT=1, 2: DIGIT=4, 3: DIGIT=8
  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_adder #(
      .WIDTH (8),
      .DIGIT ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8)
    ) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start_v[g]),
      .A     (A),
      .B     (B),
      .ci    (ci),
      .sub   (sub),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .S     (s_v[g]),
      .co    (co_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  function automatic int ndig_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : (i == 2) ? 2 : 1;
  endfunction

  // Reference: {ovf, co, S} from full-width arithmetic and operand/result signs.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    logic [8:0] full;
    logic       v;
    if (s) begin
      full = {1'b0, a} + {1'b0, ~b} + 9'd1;
      v    = (a[7] != b[7]) && (full[7] != a[7]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      v    = (a[7] == b[7]) && (full[7] != a[7]);
    end
    return {v, full};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start all four instances on one operand set and check result, latency and busy length.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input logic [7:0] es, input logic eco,
                        input logic eov, input string tag);
    int         dn  [4];
    int         bz  [4];
    int         lat [4];
    logic [7:0] rs  [4];
    logic       rco [4];
    logic       rov [4];
    for (int i = 0; i < 4; i++) begin
      dn[i] = 0; bz[i] = 0; lat[i] = -1; rs[i] = 'x; rco[i] = 'x; rov[i] = 'x;
    end
    A = a; B = b; ci = c; sub = s; start_v = 4'hF;
    @(posedge clk); #1;
    start_v = 4'h0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        if (busy_v[i]) bz[i]++;
        if (done_v[i]) begin
          dn[i]++; lat[i] = k; rs[i] = s_v[i]; rco[i] = co_v[i]; rov[i] = ovf_v[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s/i%0d S", tag, i), 32'(rs[i]), 32'(es));
      chk($sformatf("%s/i%0d co", tag, i), 32'(rco[i]), 32'(eco));
      chk($sformatf("%s/i%0d ovf", tag, i), 32'(rov[i]), 32'(eov));
      chk($sformatf("%s/i%0d latency", tag, i), 32'(lat[i]), 32'(ndig_of(i)));
      chk($sformatf("%s/i%0d busy_cycles", tag, i), 32'(bz[i]), 32'(ndig_of(i)));
      chk($sformatf("%s/i%0d done_pulses", tag, i), 32'(dn[i]), 32'd1);
    end
  endtask

  initial begin
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc, rsb;
    int         nd;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset busy", 32'(busy_v), 32'h0);
    chk("reset done", 32'(done_v), 32'h0);
    chk("reset S0", 32'(s_v[0]), 32'h0);
    chk("reset co", 32'(co_v), 32'h0);
    chk("reset ovf", 32'(ovf_v), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic add / subtract vectors
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "t1_5a+3c");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "t2_ff+01");
    run_op(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, "t2_ci");
    run_op(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "t3_10-20");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "t3_80-01");

    // Start during RUN ignored; start held in DONE accepted back-to-back (instance 0)
    A = 8'h5A; B = 8'h3C; ci = 1'b0; sub = 1'b0; start_v = 4'b0001;
    @(posedge clk); #1;
    start_v = 4'b0000; A = 8'hFF; B = 8'hFF; sub = 1'b1;
    @(posedge clk); #1;
    start_v = 4'b0001;
    @(posedge clk); #1;
    start_v = 4'b0000;
    @(posedge clk); #1;
    chk("t4 no early done", 32'(done_v[0]), 32'd0);
    @(posedge clk); #1;
    chk("t4 done", 32'(done_v[0]), 32'd1);
    chk("t4 S first", 32'(s_v[0]), 32'h96);
    chk("t4 co first", 32'(co_v[0]), 32'd0);
    chk("t4 ovf first", 32'(ovf_v[0]), 32'd1);
    A = 8'h10; B = 8'h20; sub = 1'b1; start_v = 4'b0001;
    @(posedge clk); #1;
    start_v = 4'b0000;
    chk("t4 b2b busy", 32'(busy_v[0]), 32'd1);
    chk("t4 b2b done low", 32'(done_v[0]), 32'd0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("t4 S held", 32'(s_v[0]), 32'h96);
    @(posedge clk); #1;
    chk("t4 second done", 32'(done_v[0]), 32'd1);
    chk("t4 second S", 32'(s_v[0]), 32'hF0);
    chk("t4 second co", 32'(co_v[0]), 32'd0);
    chk("t4 second ovf", 32'(ovf_v[0]), 32'd0);
    @(posedge clk); #1;

    // Reset after the second RUN digit abandons the operation
    A = 8'h5A; B = 8'h3C; ci = 1'b0; sub = 1'b0; start_v = 4'b0001;
    @(posedge clk); #1;
    start_v = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("t5 busy", 32'(busy_v[0]), 32'd0);
    chk("t5 done", 32'(done_v[0]), 32'd0);
    chk("t5 S", 32'(s_v[0]), 32'h0);
    chk("t5 co", 32'(co_v[0]), 32'd0);
    chk("t5 ovf", 32'(ovf_v[0]), 32'd0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) nd++;
    end
    chk("t5 no done after reset", 32'(nd), 32'd0);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "t5_fresh");

    // Random sweep across all four DIGIT settings
    for (int n = 0; n < 200; n++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rc  = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      m   = model(ra, rb, rc, rsb);
      run_op(ra, rb, rc, rsb, m[7:0], m[8], m[9], $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
